// File: rtl/seq_window_comparator_if.sv
// Sample/result bus for seq_window_comparator.
// master: the side that supplies samples and consumes results.
// slave:  the comparator itself.
interface seq_window_comparator_if #(
  parameter int unsigned N = 8
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic [N-1:0] lo;
  logic [N-1:0] hi;
  logic         out_valid;
  logic         out_ready;
  logic         equal;
  logic         greater;
  logic         less;
  logic         in_win;
  logic         alarm;
  logic [15:0]  evt_cnt;

  modport master (
    output in_valid, a, b, lo, hi, out_ready,
    input  in_ready, out_valid, equal, greater, less, in_win, alarm, evt_cnt
  );

  modport slave (
    input  in_valid, a, b, lo, hi, out_ready,
    output in_ready, out_valid, equal, greater, less, in_win, alarm, evt_cnt
  );
endinterface

// File: rtl/seq_window_comparator.sv
// Registered magnitude/window comparator with a debounced out-of-window alarm.
// One-deep result stage with valid/ready flow control, 1-cycle latency.
// Optional macro SEQ_WINDOW_CMP_EVT_CNT_EN enables the 16-bit alarm-raise event
// counter; when undefined evt_cnt is tied to zero.
module seq_window_comparator #(
  parameter int unsigned N      = 8,
  parameter int unsigned DEB    = 4,
  parameter int unsigned SIGNED = 0
) (
  input logic                    clk,
  input logic                    rst,
  seq_window_comparator_if.slave bus
);

  localparam int unsigned CW = (DEB < 2) ? 1 : $clog2(DEB + 1);
  localparam logic [CW-1:0] DebC = CW'(DEB);
  localparam logic SignExt = (SIGNED != 0);

  typedef enum logic [1:0] {StIdle, StArming, StAlarm, StClearing} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;

  logic out_valid_q;
  logic equal_q, greater_q, less_q, in_win_q;

  logic accept;
  logic signed [N:0] a_x, b_x, lo_x, hi_x;
  logic equal_d, greater_d, less_d, in_win_d;

  // Widen by one bit so a single signed compare serves both signedness modes.
  always_comb begin
    a_x  = {SignExt & bus.a[N-1],  bus.a};
    b_x  = {SignExt & bus.b[N-1],  bus.b};
    lo_x = {SignExt & bus.lo[N-1], bus.lo};
    hi_x = {SignExt & bus.hi[N-1], bus.hi};
    equal_d   = (a_x == b_x);
    greater_d = (a_x > b_x);
    less_d    = (a_x < b_x);
    // An inverted window (lo > hi) never contains a sample.
    in_win_d  = (lo_x <= hi_x) && (lo_x <= a_x) && (a_x <= hi_x);
  end

  // Handshake: a new sample is taken whenever the result slot is free or draining.
  always_comb begin
    bus.in_ready = !rst && (!out_valid_q || bus.out_ready);
    accept       = bus.in_valid && bus.in_ready;
  end

  // Result stage: capture on accept, drop valid once consumed with nothing new.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      equal_q     <= 1'b0;
      greater_q   <= 1'b0;
      less_q      <= 1'b0;
      in_win_q    <= 1'b0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      equal_q     <= equal_d;
      greater_q   <= greater_d;
      less_q      <= less_d;
      in_win_q    <= in_win_d;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  // Debounce next-state: only accepted samples move the FSM.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cnt_inc = cnt_q + 1'b1;
    if (accept) begin
      unique case (state_q)
        StIdle, StArming: begin
          if (!in_win_d) begin
            if (cnt_inc == DebC) begin
              state_d = StAlarm;
              cnt_d   = '0;
            end else begin
              state_d = StArming;
              cnt_d   = cnt_inc;
            end
          end else begin
            state_d = StIdle;
            cnt_d   = '0;
          end
        end
        StAlarm, StClearing: begin
          if (in_win_d) begin
            if (cnt_inc == DebC) begin
              state_d = StIdle;
              cnt_d   = '0;
            end else begin
              state_d = StClearing;
              cnt_d   = cnt_inc;
            end
          end else begin
            state_d = StAlarm;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Debounce state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef SEQ_WINDOW_CMP_EVT_CNT_EN
  logic [15:0] evt_q;
  logic        raise;

  // A raise is entry into StAlarm from the quiet side; re-entry from StClearing is not.
  always_comb begin
    raise = accept && (state_d == StAlarm) &&
            ((state_q == StIdle) || (state_q == StArming));
  end

  // Saturating alarm-raise counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      evt_q <= '0;
    end else if (raise && (evt_q != 16'hFFFF)) begin
      evt_q <= evt_q + 16'd1;
    end
  end

  assign bus.evt_cnt = evt_q;
`else
  assign bus.evt_cnt = '0;
`endif

  // Registered outputs; alarm follows the FSM, which only moves on accept.
  always_comb begin
    bus.out_valid = out_valid_q;
    bus.equal     = equal_q;
    bus.greater   = greater_q;
    bus.less      = less_q;
    bus.in_win    = in_win_q;
    bus.alarm     = (state_q == StAlarm) || (state_q == StClearing);
  end

endmodule

// File: tb/tb_seq_window_comparator.sv
// Self-checking bench: an unsigned and a signed instance (N=8, DEB=3) share the
// same stimulus and are compared each cycle against an integer reference model.
module tb_seq_window_comparator;

  localparam int unsigned N   = 8;
  localparam int unsigned DEB = 3;

  logic clk;
  logic rst;

  seq_window_comparator_if #(.N(N)) bus   ();
  seq_window_comparator_if #(.N(N)) bus_s ();

  seq_window_comparator #(.N(N), .DEB(DEB), .SIGNED(0)) dut_u (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  seq_window_comparator #(.N(N), .DEB(DEB), .SIGNED(1)) dut_s (
    .clk (clk),
    .rst (rst),
    .bus (bus_s)
  );

  assign bus_s.in_valid  = bus.in_valid;
  assign bus_s.a         = bus.a;
  assign bus_s.b         = bus.b;
  assign bus_s.lo        = bus.lo;
  assign bus_s.hi        = bus.hi;
  assign bus_s.out_ready = bus.out_ready;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  // Reference model: index 0 = unsigned view, 1 = signed view.
  logic m_ov;
  logic m_eq [2];
  logic m_gt [2];
  logic m_lt [2];
  logic m_win [2];
  logic m_alarm [2];
  int   m_run [2];
  int   m_evt [2];

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ov = 1'b0;
    for (int s = 0; s < 2; s++) begin
      m_eq[s] = 0; m_gt[s] = 0; m_lt[s] = 0; m_win[s] = 0;
      m_alarm[s] = 0; m_run[s] = 0; m_evt[s] = 0;
    end
  endtask

  // Integer view of a byte under the chosen signedness.
  function automatic int val(input int s, input logic [7:0] x);
    return (s != 0) ? int'($signed(x)) : int'(x);
  endfunction

  task automatic model_accept(input logic [7:0] ta, input logic [7:0] tb_,
                              input logic [7:0] tlo, input logic [7:0] thi);
    int ia, ib, il, ih;
    m_ov = 1'b1;
    for (int s = 0; s < 2; s++) begin
      ia = val(s, ta); ib = val(s, tb_); il = val(s, tlo); ih = val(s, thi);
      m_eq[s]  = (ia == ib);
      m_gt[s]  = (ia > ib);
      m_lt[s]  = (ia < ib);
      m_win[s] = (il <= ia) && (ia <= ih);
      // Alarm toggles after DEB consecutive samples on the opposite side.
      if (!m_alarm[s]) begin
        m_run[s] = m_win[s] ? 0 : m_run[s] + 1;
        if (m_run[s] == int'(DEB)) begin
          m_alarm[s] = 1'b1;
          m_run[s]   = 0;
          if (m_evt[s] < 65535) m_evt[s]++;
        end
      end else begin
        m_run[s] = m_win[s] ? m_run[s] + 1 : 0;
        if (m_run[s] == int'(DEB)) begin
          m_alarm[s] = 1'b0;
          m_run[s]   = 0;
        end
      end
    end
  endtask

  task automatic check_outputs();
    logic [15:0] e0, e1;
`ifdef SEQ_WINDOW_CMP_EVT_CNT_EN
    e0 = 16'(m_evt[0]);
    e1 = 16'(m_evt[1]);
`else
    e0 = 16'd0;
    e1 = 16'd0;
`endif
    check1("u.out_valid", bus.out_valid, m_ov);
    check1("u.equal",     bus.equal,     m_eq[0]);
    check1("u.greater",   bus.greater,   m_gt[0]);
    check1("u.less",      bus.less,      m_lt[0]);
    check1("u.in_win",    bus.in_win,    m_win[0]);
    check1("u.alarm",     bus.alarm,     m_alarm[0]);
    check16("u.evt_cnt",  bus.evt_cnt,   e0);
    check1("s.out_valid", bus_s.out_valid, m_ov);
    check1("s.equal",     bus_s.equal,     m_eq[1]);
    check1("s.greater",   bus_s.greater,   m_gt[1]);
    check1("s.less",      bus_s.less,      m_lt[1]);
    check1("s.in_win",    bus_s.in_win,    m_win[1]);
    check1("s.alarm",     bus_s.alarm,     m_alarm[1]);
    check16("s.evt_cnt",  bus_s.evt_cnt,   e1);
  endtask

  // One clock: drive after negedge, check ready, update model, check after posedge.
  task automatic step(input logic r, input logic v, input logic [7:0] ta,
                      input logic [7:0] tb_, input logic [7:0] tlo,
                      input logic [7:0] thi, input logic ordy);
    logic exp_rdy;
    @(negedge clk);
    rst           = r;
    bus.in_valid  = v;
    bus.a         = ta;
    bus.b         = tb_;
    bus.lo        = tlo;
    bus.hi        = thi;
    bus.out_ready = ordy;
    #1;
    exp_rdy = !r && (!m_ov || ordy);
    check1("u.in_ready", bus.in_ready, exp_rdy);
    check1("s.in_ready", bus_s.in_ready, exp_rdy);
    if (r) model_reset();
    else if (v && exp_rdy) model_accept(ta, tb_, tlo, thi);
    else if (m_ov && ordy) m_ov = 1'b0;
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic sample(input logic [7:0] ta);
    step(1'b0, 1'b1, ta, 8'd5, 8'd10, 8'd20, 1'b1);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 8'd0, 8'd0, 8'd10, 8'd20, 1'b1);
    step(1'b1, 1'b1, 8'd30, 8'd0, 8'd10, 8'd20, 1'b1);
  endtask

  initial begin
    logic [7:0] ra, rb, rl, rh;
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.lo = 8'd10; bus.hi = 8'd20;
    bus.out_ready = 1'b1;
    model_reset();

    // Reset state, then a=5,b=5.
    do_reset();
    step(1'b0, 1'b1, 8'd5, 8'd5, 8'd10, 8'd20, 1'b1);
    check1("r035_equal", bus.equal, 1'b1);
    check1("r035_in_win", bus.in_win, 1'b0);
    check1("r035_alarm", bus.alarm, 1'b0);

    // Three out-of-window samples raise alarm on the third result.
    do_reset();
    sample(8'd25);
    sample(8'd30);
    check1("r036_alarm_early", bus.alarm, 1'b0);
    sample(8'd2);
    check1("r036_alarm", bus.alarm, 1'b1);

    // Interrupted clearing run, then a full clearing run.
    sample(8'd15);
    sample(8'd15);
    sample(8'd30);
    sample(8'd15);
    sample(8'd15);
    check1("r037_alarm_hold", bus.alarm, 1'b1);
    sample(8'd15);
    check1("r037_alarm_clear", bus.alarm, 1'b0);

    // Backpressure: hold result a=12 for 4 stalled cycles.
    sample(8'd12);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 8'd25, 8'd5, 8'd10, 8'd20, 1'b0);
      check1("r038_hold_in_win", bus.in_win, 1'b1);
    end
    step(1'b0, 1'b1, 8'd25, 8'd5, 8'd10, 8'd20, 1'b1);
    check1("r038_release_in_win", bus.in_win, 1'b0);

    // Reset in the middle of an arming run discards the partial count.
    do_reset();
    sample(8'd40);
    sample(8'd41);
    do_reset();
    sample(8'd42);
    check1("r040_alarm", bus.alarm, 1'b0);

    // Signed vs unsigned interpretation, inverted unsigned window.
    step(1'b0, 1'b1, 8'hF0, 8'h05, 8'hEC, 8'h00, 1'b1);
    check1("r039_s_less", bus_s.less, 1'b1);
    check1("r039_s_in_win", bus_s.in_win, 1'b1);
    check1("r039_u_greater", bus.greater, 1'b1);
    check1("r039_u_in_win", bus.in_win, 1'b0);

    // Randomised traffic with stalls, window edges and occasional resets.
    for (int i = 0; i < 600; i++) begin
      ra = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(5, 25));
      rb = ($urandom_range(0, 3) == 0) ? ra : 8'($urandom);
      if ($urandom_range(0, 7) == 0) begin
        rl = 8'($urandom);
        rh = 8'($urandom);
      end else begin
        rl = 8'd10;
        rh = 8'd20;
      end
      step(($urandom_range(0, 79) == 0), ($urandom_range(0, 3) != 0), ra, rb, rl, rh,
           ($urandom_range(0, 2) != 0));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/seq_window_comparator.md
SEQ_WINDOW_COMPARATOR -- requirements
Module: seq_window_comparator

Interface
REQ-001 Parameter N, default 8: operand and threshold width in bits, N >= 2.
REQ-002 Parameter DEB, default 4: consecutive accepted samples needed to raise or clear alarm, DEB >= 1.
REQ-003 Parameter SIGNED, default 0: 0 = unsigned compares, 1 = two's-complement compares.
REQ-004 clk  in  1  sole clock, all state updates on its rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 in_valid  in  1  input sample valid.
REQ-007 in_ready  out  1  block can accept a sample this cycle.
REQ-008 a  in  N  sample operand.
REQ-009 b  in  N  reference operand, sampled with a.
REQ-010 lo  in  N  window lower bound, inclusive, sampled with a.
REQ-011 hi  in  N  window upper bound, inclusive, sampled with a.
REQ-012 out_valid  out  1  result registers hold a valid result.
REQ-013 out_ready  in  1  downstream accepts the result.
REQ-014 equal, greater, less  out  1 each  registered a==b, a>b, a<b.
REQ-015 in_win  out  1  registered lo <= a <= hi.
REQ-016 alarm  out  1  debounced out-of-window flag.
REQ-017 evt_cnt  out  16  alarm-raise event count; see Configuration.

Function
REQ-018 Accept SHALL occur on a rising edge where in_valid && in_ready.
REQ-019 in_ready SHALL equal !rst && (!out_valid || out_ready), combinational.
REQ-020 Latency SHALL be 1 cycle: the result of a sample accepted at edge k is presented with out_valid=1 after edge k.
REQ-021 out_valid SHALL clear on an edge with out_valid && out_ready and no accept; back-to-back accepts SHALL sustain 1 sample/cycle.
REQ-022 While out_valid && !out_ready, all result outputs and alarm SHALL hold stable.
REQ-023 Exactly one of equal/greater/less SHALL be 1 whenever out_valid=1; signedness follows SIGNED.
REQ-024 If lo > hi (per SIGNED), in_win SHALL be 0 for that sample.
REQ-025 Debounce FSM states IDLE, ARMING, ALARM, CLEARING; it advances only on accept; counter cnt saturates at DEB.
REQ-026 IDLE: out-of-window sample -> ARMING with cnt=1, or directly -> ALARM if DEB=1; in-window stays IDLE.
REQ-027 ARMING: out-of-window increments cnt, reaching DEB -> ALARM; in-window -> IDLE, cnt=0.
REQ-028 ALARM: in-window -> CLEARING with cnt=1, or directly -> IDLE if DEB=1; out-of-window stays ALARM.
REQ-029 CLEARING: in-window increments cnt, reaching DEB -> IDLE; out-of-window -> ALARM, cnt=0.
REQ-030 alarm SHALL be 1 in ALARM and CLEARING, and SHALL update on the same edge as the result of the sample that caused the transition.

Reset
REQ-031 While rst=1 at an edge: out_valid, equal, greater, less, in_win, alarm = 0; FSM = IDLE; cnt = 0; evt_cnt = 0.
REQ-032 An in-flight result and any partial debounce count SHALL be discarded by reset; no sample is accepted while rst=1.

Configuration
REQ-033 Macro SEQ_WINDOW_CMP_EVT_CNT_EN defined: evt_cnt SHALL increment by 1 on every transition into ALARM from IDLE or ARMING and saturate at 16'hFFFF.
REQ-034 Macro undefined: evt_cnt SHALL be constant 0 and no counter logic SHALL be synthesised; the port list is unchanged.

Verification (N=8, DEB=3, SIGNED=0, lo=10, hi=20 unless stated)
REQ-035 Reset, then a=5,b=5 accepted -> next cycle out_valid=1, equal=1, in_win=0, alarm=0, FSM=ARMING.
REQ-036 Samples 25,30,2 back-to-back with out_ready=1 -> alarm rises with the third result; evt_cnt=1 (macro on) or 0 (macro off).
REQ-037 In ALARM, feed 15,15,30,15,15,15 -> alarm stays 1 through the 30, then clears with the final 15.
REQ-038 out_ready=0 for 4 cycles holding result a=12 -> in_ready=0, outputs stable, next sample not accepted until out_ready=1.
REQ-039 SIGNED=1, a=8'hF0, b=8'h05, lo=8'hEC, hi=8'h00 -> less=1, in_win=1; same vectors with SIGNED=0 -> greater=1, in_win=0 (lo>hi).
REQ-040 rst asserted mid-ARMING with cnt=2 -> all outputs 0; after release, one out-of-window sample leaves alarm=0.
